// File: rtl/bit_counter_arbiter_if.sv
// rtl/bit_counter_arbiter_if.sv - requester/counter-unit signal bundle for bit_counter_arbiter
interface bit_counter_arbiter_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1),
  parameter int GW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [CW-1:0]  rsp_count;
  logic           rsp_err;
  logic           busy;
  logic [GW-1:0]  grant_id;
  logic           cnt_start;
  logic [W-1:0]   cnt_data;
  logic           cnt_done;
  logic [CW-1:0]  cnt_count;

  modport master (
    output req, req_data, cnt_done, cnt_count,
    input  ack, rsp_count, rsp_err, busy, grant_id, cnt_start, cnt_data
  );

  modport slave (
    input  req, req_data, cnt_done, cnt_count,
    output ack, rsp_count, rsp_err, busy, grant_id, cnt_start, cnt_data
  );
endinterface

// File: rtl/bit_counter_arbiter.sv
// rtl/bit_counter_arbiter.sv - round-robin sharing of one bit-counter unit; BCA_TIMEOUT_EN adds a WAIT abort
module bit_counter_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int CW      = $clog2(W + 1),
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  bit_counter_arbiter_if.slave bus
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] grant_q;
  logic [N-1:0]  ack_q;
  logic [CW-1:0] rsp_count_q;
  logic          busy_q;
  logic          cnt_start_q;
  logic [W-1:0]  cnt_data_q;
  logic          expire;

  logic [W-1:0]  data_arr [N];
  logic [GW-1:0] cand;
  logic [GW-1:0] pick_idx;
  logic          pick_found;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      data_arr[i] = bus.req_data[i*W +: W];
    end
  end

  // Search starts one past the last grantee and wraps, so nobody is starved.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = GW'((int'(last_grant) + k) % N);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      last_grant  <= GW'(N - 1);
      grant_q     <= '0;
      ack_q       <= '0;
      rsp_count_q <= '0;
      busy_q      <= 1'b0;
      cnt_start_q <= 1'b0;
      cnt_data_q  <= '0;
    end else begin
      ack_q       <= '0;
      cnt_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_q     <= pick_idx;
            cnt_data_q  <= data_arr[pick_idx];
            cnt_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.cnt_done || expire) begin
            rsp_count_q <= bus.cnt_done ? bus.cnt_count : '0;
            ack_q       <= N'(1) << grant_q;
            state       <= RESP;
          end
        end
        RESP: begin
          last_grant <= grant_q;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;
  logic          rsp_err_q;

  // Expiry fires at the end of the TIMEOUT-th WAIT cycle; a coincident done wins.
  assign expire = (state == WAIT) && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == WAIT && (bus.cnt_done || expire)) begin
        rsp_err_q <= !bus.cnt_done;
      end
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign expire      = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.ack       = ack_q;
  assign bus.rsp_count = rsp_count_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
  assign bus.cnt_start = cnt_start_q;
  assign bus.cnt_data  = cnt_data_q;
endmodule

// File: tb/tb_bit_counter_arbiter.sv
// tb/tb_bit_counter_arbiter.sv - directed vector bench for bit_counter_arbiter
module tb_bit_counter_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  bit_counter_arbiter_if #(.N(N), .W(W), .CW(CW)) bus ();

  bit_counter_arbiter #(.N(N), .W(W), .CW(CW), .TIMEOUT(64)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Counter-unit stub: the result is the population count of the issued operand.
  assign bus.cnt_count = CW'($countones(bus.cnt_data));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    int             delay;
    logic [N-1:0]   exp_ack;
    logic [W-1:0]   exp_data;
    logic [CW-1:0]  exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic wait_start(input string name, output bit seen);
    int t;
    t = 0;
    seen = 0;
    while (!seen && t < 8) begin
      @(negedge clk);
      t++;
      if (bus.cnt_start) seen = 1;
    end
    check({name, "_start_latency"}, t, seen ? 1 : 0);
  endtask

  task automatic run_txn(input string name, input logic [N-1:0] rq, input logic [N*W-1:0] data,
                         input int delay, input bit drop_early, input logic [N-1:0] exp_ack,
                         input logic [W-1:0] exp_data, input logic [CW-1:0] exp_cnt);
    bit seen;
    int gid;
    int stray;
    gid = 0;
    for (int i = 0; i < N; i++) if (exp_ack[i]) gid = i;
    bus.req = rq;
    bus.req_data = data;
    wait_start(name, seen);
    if (!seen) begin
      bus.req = '0;
      return;
    end
    check({name, "_cnt_data"}, bus.cnt_data, exp_data);
    check({name, "_grant_id"}, bus.grant_id, gid);
    if (drop_early) bus.req = '0;
    bus.req_data = ~data;
    stray = 0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (bus.cnt_start || bus.ack != '0 || !bus.busy) stray++;
    end
    check({name, "_wait_quiet"}, stray, 0);
    check({name, "_cnt_data_held"}, bus.cnt_data, exp_data);
    bus.cnt_done = 1'b1;
    @(negedge clk);
    bus.cnt_done = 1'b0;
    check({name, "_ack"}, bus.ack, exp_ack);
    check({name, "_rsp_count"}, bus.rsp_count, exp_cnt);
    check({name, "_rsp_err"}, bus.rsp_err, 0);
    bus.req = '0;
    @(negedge clk);
    check({name, "_ack_clear"}, bus.ack, 0);
    check({name, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int ack_id [$];
    int ack_t [$];
    int quiet;
    bit seen;

    vecs[0] = '{4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 3, 4'b0100, 8'hA5, 4'd4};
    vecs[1] = '{4'b1011, {8'hFF, 8'h12, 8'h34, 8'h56}, 1, 4'b1000, 8'hFF, 4'd8};
    vecs[2] = '{4'b0011, {8'h00, 8'h00, 8'h81, 8'h00}, 2, 4'b0001, 8'h00, 4'd0};
    vecs[3] = '{4'b0011, {8'h00, 8'h00, 8'h81, 8'h00}, 1, 4'b0010, 8'h81, 4'd2};
    vecs[4] = '{4'b0001, {8'h11, 8'h22, 8'h33, 8'h7F}, 4, 4'b0001, 8'h7F, 4'd7};
    vecs[5] = '{4'b1111, {8'hC0, 8'hE0, 8'h01, 8'h02}, 2, 4'b0010, 8'h01, 4'd1};

    bus.req = '0;
    bus.req_data = '0;
    bus.cnt_done = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_ack", bus.ack, 0);
    check("reset_cnt_start", bus.cnt_start, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    check("reset_rsp_count", bus.rsp_count, 0);
    check("reset_cnt_data", bus.cnt_data, 0);
    check("reset_grant_id", bus.grant_id, 0);

    for (int v = 0; v < 6; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].req, vecs[v].data, vecs[v].delay, 1'b0,
              vecs[v].exp_ack, vecs[v].exp_data, vecs[v].exp_cnt);
    end

    // All four requesting with an instantly answering counter unit.
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    bus.req_data = {8'h0F, 8'h07, 8'h03, 8'h01};
    bus.req = '1;
    bus.cnt_done = 1'b1;
    for (int c = 0; c < 40 && ack_id.size() < 5; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        check("rr_onehot", $countones(bus.ack), 1);
        for (int i = 0; i < N; i++) begin
          if (bus.ack[i]) begin
            ack_id.push_back(i);
            check($sformatf("rr_count_id%0d", i), bus.rsp_count, i + 1);
          end
        end
        ack_t.push_back(c);
        if (ack_id.size() >= 5) bus.req = '0;
      end
    end
    bus.cnt_done = 1'b0;
    check("rr_num_acks", ack_id.size(), 5);
    for (int i = 0; i < ack_id.size(); i++) begin
      check($sformatf("rr_order%0d", i), ack_id[i], i % N);
      if (i > 0 && i < ack_t.size()) check($sformatf("rr_spacing%0d", i), ack_t[i] - ack_t[i-1], 4);
    end
    @(negedge clk);
    check("rr_idle_after", bus.busy, 0);

    // Stray done in IDLE must be ignored, then req[1] dropped right after grant.
    bus.cnt_done = 1'b1;
    @(negedge clk);
    bus.cnt_done = 1'b0;
    @(negedge clk);
    check("stray_done_busy", bus.busy, 0);
    check("stray_done_ack", bus.ack, 0);
    run_txn("drop", 4'b0010, {8'h00, 8'h00, 8'h3C, 8'h00}, 2, 1'b1, 4'b0010, 8'h3C, 4'd4);

    // Reset in the middle of WAIT abandons the transaction.
    bus.req = 4'b0001;
    bus.req_data = {24'h0, 8'hF0};
    wait_start("rst_mid", seen);
    bus.req = '0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_ack", bus.ack, 0);
    check("rst_mid_cnt_data", bus.cnt_data, 0);
    resetn = 1'b1;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack != '0 || bus.busy) quiet++;
    end
    check("rst_mid_no_ack", quiet, 0);
    run_txn("after_rst", 4'b0001, {24'h0, 8'hF0}, 1, 1'b0, 4'b0001, 8'hF0, 4'd4);

`ifdef BCA_TIMEOUT_EN
    begin
      int c;
      bus.req = 4'b0100;
      bus.req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
      wait_start("tmo", seen);
      bus.req = '0;
      c = 0;
      while (seen && c < 100) begin
        @(negedge clk);
        c++;
        if (bus.ack != '0) break;
      end
      check("tmo_latency", c, 65);
      check("tmo_ack", bus.ack, 4'b0100);
      check("tmo_rsp_err", bus.rsp_err, 1);
      check("tmo_rsp_count", bus.rsp_count, 0);
      @(negedge clk);
      check("tmo_idle", bus.busy, 0);
      run_txn("tmo_edge", 4'b0001, {24'h0, 8'h33}, 64, 1'b0, 4'b0001, 8'h33, 4'd4);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
